lif_neuron_array: RTL and testbench

Parametrised array of N_CH leaky integrate-and-fire neurons, the multi-channel successor to the single-neuron LIF core wrapped by the TinyTapeout top level. Each channel integrates its own input current with a programmable shift leak, fires against a shared threshold, and supports two post-spike reset modes and a refractory period. A saturating spike counter across all channels is provided. The top-level wrapper maps its inputs, outputs and bidirectional pins onto this block's ports.

---
 rtl/lif_neuron_array.sv | 105 ++++++++++
 tb/tb_lif_neuron_array.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// Array of N_CH leaky integrate-and-fire neurons sharing threshold, leak and
// refractory settings, with a saturating spike counter across all channels.
module lif_neuron_array #(
    parameter int N_CH     = 4,
    parameter int W        = 8,
    parameter int REFRAC_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N_CH*W-1:0]     current,
    input  logic [W-1:0]          threshold,
    input  logic [2:0]            leak_shift,
    input  logic                  reset_mode,
    input  logic [REFRAC_W-1:0]   refrac_cycles,
    input  logic                  count_clr,
    output logic [N_CH*W-1:0]     state,
    output logic [N_CH-1:0]       spike,
    output logic [CNT_W-1:0]      spike_count
);

    localparam int PC_W = $clog2(N_CH + 1);

    function automatic logic [W-1:0] sat_state(input logic [W:0] v);
        return v[W] ? {W{1'b1}} : v[W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W:0] v);
        return v[CNT_W] ? {CNT_W{1'b1}} : v[CNT_W-1:0];
    endfunction

    logic [N_CH-1:0]  spike_p0;
    logic [N_CH-1:0]  spike_p1;
    logic [PC_W-1:0]  pop_p0;
    logic [CNT_W-1:0] count_p0;
    logic [CNT_W-1:0] count_p1;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [W-1:0]        cur_p0;
        logic [W-1:0]        decay_p0;
        logic [W-1:0]        leaked_p0;
        logic [W:0]          sum_p0;
        logic [W-1:0]        sum_sat_p0;
        logic                refrac_busy_p0;
        logic                fire_p0;
        logic [W-1:0]        state_p1;
        logic [REFRAC_W-1:0] refrac_p1;

        // decay never exceeds state, so the leak subtraction cannot wrap
        assign cur_p0         = current[ch*W +: W];
        assign decay_p0       = (leak_shift == 3'd0) ? '0 : (state_p1 >> leak_shift);
        assign leaked_p0      = state_p1 - decay_p0;
        assign sum_p0         = {1'b0, leaked_p0} + {1'b0, cur_p0};
        assign sum_sat_p0     = sat_state(sum_p0);
        assign refrac_busy_p0 = (refrac_p1 != '0);
        assign fire_p0        = en && !refrac_busy_p0 && (sum_sat_p0 >= threshold);
        assign spike_p0[ch]   = fire_p0;

        // ---- stage p1: membrane and refractory registers ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_p1  <= '0;
                refrac_p1 <= '0;
            end else if (en) begin
                if (refrac_busy_p0) begin
                    refrac_p1 <= refrac_p1 - REFRAC_W'(1);
                end else if (fire_p0) begin
                    refrac_p1 <= refrac_cycles;
                    state_p1  <= reset_mode ? (sum_sat_p0 - threshold) : '0;
                end else begin
                    state_p1  <= sum_sat_p0;
                end
            end
        end

        assign state[ch*W +: W] = state_p1;
    end

    always_comb begin
        pop_p0 = '0;
        for (int i = 0; i < N_CH; i++) begin
            pop_p0 = pop_p0 + PC_W'(spike_p0[i]);
        end
    end

    // Clear wins over the increment arriving on the same edge.
    assign count_p0 = count_clr ? '0
                    : sat_count({1'b0, count_p1} + (CNT_W + 1)'(pop_p0));

    // ---- stage p1: spike pulses and counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_p1 <= '0;
            count_p1 <= '0;
        end else begin
            spike_p1 <= spike_p0;
            count_p1 <= count_p0;
        end
    end

    assign spike       = spike_p1;
    assign spike_count = count_p1;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed table-driven bench for lif_neuron_array with hand-computed
// expected state, spike and spike_count per step.
module tb_lif_neuron_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] current;
    logic [7:0]  threshold;
    logic [2:0]  leak_shift;
    logic        reset_mode;
    logic [3:0]  refrac_cycles;
    logic        count_clr;
    logic [31:0] state;
    logic [3:0]  spike;
    logic [15:0] spike_count;

    lif_neuron_array #(.N_CH(4), .W(8), .REFRAC_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .current(current),
        .threshold(threshold), .leak_shift(leak_shift), .reset_mode(reset_mode),
        .refrac_cycles(refrac_cycles), .count_clr(count_clr),
        .state(state), .spike(spike), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_rst;
        bit          en;
        logic [31:0] cur;
        logic [7:0]  thr;
        logic [2:0]  lk;
        bit          md;
        logic [3:0]  rf;
        bit          clr;
        logic [31:0] exp_state;
        logic [3:0]  exp_spike;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input bit r, input bit e, input logic [31:0] cur,
                       input logic [7:0] thr, input logic [2:0] lk, input bit md,
                       input logic [3:0] rf, input bit clr, input logic [31:0] st,
                       input logic [3:0] sp, input logic [15:0] cn);
        vec_t v;
        v.do_rst = r; v.en = e; v.cur = cur; v.thr = thr; v.lk = lk; v.md = md;
        v.rf = rf; v.clr = clr; v.exp_state = st; v.exp_spike = sp; v.exp_cnt = cn;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h want %h", name, idx, got, want);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_all(input string tag, input int idx, input logic [31:0] st,
                             input logic [3:0] sp, input logic [15:0] cn);
        check({tag, ".state"}, idx, state, st);
        check({tag, ".spike"}, idx, {28'd0, spike}, {28'd0, sp});
        check({tag, ".count"}, idx, {16'd0, spike_count}, {16'd0, cn});
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; current = '0; threshold = '0; leak_shift = '0;
        reset_mode = 1'b0; refrac_cycles = '0; count_clr = 1'b0;

        // integrate and fire, period 4
        add(1,1,32'h1E,100,0,0,0,0, 32'h1E,4'h0,0);
        add(0,1,32'h1E,100,0,0,0,0, 32'h3C,4'h0,0);
        add(0,1,32'h1E,100,0,0,0,0, 32'h5A,4'h0,0);
        add(0,1,32'h1E,100,0,0,0,0, 32'h00,4'h1,1);
        add(0,1,32'h1E,100,0,0,0,0, 32'h1E,4'h0,1);
        add(0,1,32'h1E,100,0,0,0,0, 32'h3C,4'h0,1);
        add(0,1,32'h1E,100,0,0,0,0, 32'h5A,4'h0,1);
        add(0,1,32'h1E,100,0,0,0,0, 32'h00,4'h1,2);
        // leak steady state at 20
        add(1,1,32'h0A,200,1,0,0,0, 32'd10,4'h0,0);
        add(0,1,32'h0A,200,1,0,0,0, 32'd15,4'h0,0);
        add(0,1,32'h0A,200,1,0,0,0, 32'd18,4'h0,0);
        add(0,1,32'h0A,200,1,0,0,0, 32'd19,4'h0,0);
        add(0,1,32'h0A,200,1,0,0,0, 32'd20,4'h0,0);
        add(0,1,32'h0A,200,1,0,0,0, 32'd20,4'h0,0);
        // saturation with subtract-threshold reset
        add(1,1,32'hFF,200,0,1,0,0, 32'd55,4'h1,1);
        add(0,1,32'hFF,200,0,1,0,0, 32'd55,4'h1,2);
        add(0,1,32'hFF,200,0,1,0,0, 32'd55,4'h1,3);
        // refractory period of 3
        add(1,1,32'h3C,50,0,0,3,0, 32'd0,4'h1,1);
        add(0,1,32'h3C,50,0,0,3,0, 32'd0,4'h0,1);
        add(0,1,32'h3C,50,0,0,3,0, 32'd0,4'h0,1);
        add(0,1,32'h3C,50,0,0,3,0, 32'd0,4'h0,1);
        add(0,1,32'h3C,50,0,0,3,0, 32'd0,4'h1,2);
        add(0,1,32'h3C,50,0,0,3,0, 32'd0,4'h0,2);
        // threshold 0 fires everything
        add(1,1,32'h0,0,0,0,0,0, 32'd0,4'hF,4);
        add(0,1,32'h0,0,0,0,0,0, 32'd0,4'hF,8);
        // counter increments by 4, clear wins over increment
        add(1,1,32'hFFFFFFFF,1,0,0,0,0, 32'd0,4'hF,4);
        add(0,1,32'hFFFFFFFF,1,0,0,0,0, 32'd0,4'hF,8);
        add(0,1,32'hFFFFFFFF,1,0,0,0,1, 32'd0,4'hF,0);
        add(0,1,32'hFFFFFFFF,1,0,0,0,0, 32'd0,4'hF,4);
        // en gating: ch0 holds 60, ch1 spike pulse does not repeat
        add(1,1,32'hC83C,100,0,0,0,0, 32'h3C,4'h2,1);
        for (int k = 0; k < 5; k++) add(0,0,32'hC83C,100,0,0,0,0, 32'h3C,4'h0,1);

        #12;
        check_all("reset", -1, 32'd0, 4'h0, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_rst) pulse_reset();
            en = vecs[i].en; current = vecs[i].cur; threshold = vecs[i].thr;
            leak_shift = vecs[i].lk; reset_mode = vecs[i].md;
            refrac_cycles = vecs[i].rf; count_clr = vecs[i].clr;
            @(posedge clk); #1;
            check_all("table", i, vecs[i].exp_state, vecs[i].exp_spike, vecs[i].exp_cnt);
        end

        // asynchronous reset between edges clears outputs without a clock
        rst_n = 1'b0;
        #1;
        check_all("async_rst", -1, 32'd0, 4'h0, 16'd0);
        rst_n = 1'b1;

        // counter saturation: 16384 steps of 4 spikes reach the ceiling
        pulse_reset();
        en = 1'b1; current = 32'hFFFFFFFF; threshold = 8'd1; leak_shift = '0;
        reset_mode = 1'b0; refrac_cycles = '0; count_clr = 1'b0;
        repeat (16383) @(posedge clk);
        #1;
        check_all("sat_pre", -1, 32'd0, 4'hF, 16'd65532);
        @(posedge clk); #1;
        check_all("sat_hit", -1, 32'd0, 4'hF, 16'd65535);
        @(posedge clk); #1;
        check_all("sat_hold", -1, 32'd0, 4'hF, 16'd65535);
        count_clr = 1'b1;
        @(posedge clk); #1;
        check_all("sat_clr", -1, 32'd0, 4'hF, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
